// File: rtl/nvram_shadow_store.sv
// nvram_shadow_store: DEPTH x DATA_W SRAM with a non-volatile shadow copy, whole-array STORE/RECALL sequencer.
// Optional `NVRAM_WRITE_PROTECT_EN adds a wp input that blocks CPU writes and store requests.
module nvram_shadow_store #(
    parameter int                 DATA_W     = 4,
    parameter int                 ADDR_W     = 8,
    parameter int                 STORE_WAIT = 16,
    parameter logic [DATA_W-1:0]  INIT_VAL   = '1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] i,
    output logic [DATA_W-1:0] o,
    input  logic              ce_n,
    input  logic              rw_n,
    input  logic              store_n,
    input  logic              recall_n,
`ifdef NVRAM_WRITE_PROTECT_EN
    input  logic              wp,
`endif
    output logic              busy,
    output logic              dirty
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int WCNT_W = STORE_WAIT > 1 ? $clog2(STORE_WAIT) : 1;
    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(STORE_WAIT > 0 ? STORE_WAIT - 1 : 0);
    typedef enum logic [1:0] {IDLE, RECALL, STORE, SWAIT} state_t;
    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [WCNT_W-1:0]   wcnt;
    logic                store_q, recall_q;
    logic                wp_on, store_req, recall_req, cpu_wr;
    logic [DATA_W-1:0]   sram [DEPTH];
    // The shadow models EEPROM contents, so it starts at INIT_VAL and is never reset.
    logic [DATA_W-1:0]   shadow [DEPTH] = '{default: INIT_VAL};
`ifdef NVRAM_WRITE_PROTECT_EN
    assign wp_on = wp;
`else
    assign wp_on = 1'b0;
`endif
    assign store_req  = store_q & ~store_n & ~wp_on;
    assign recall_req = recall_q & ~recall_n;
    assign cpu_wr     = (state == IDLE) & ~ce_n & ~rw_n & ~wp_on;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RECALL;
            cnt      <= '0;
            wcnt     <= '0;
            busy     <= 1'b1;
            dirty    <= 1'b0;
            o        <= '0;
            store_q  <= 1'b1;
            recall_q <= 1'b1;
        end else begin
            store_q  <= store_n;
            recall_q <= recall_n;
            o        <= sram[a];
            case (state)
                IDLE: begin
                    if (cpu_wr) dirty <= 1'b1;
                    if (recall_req) begin
                        state <= RECALL;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else if (store_req) begin
                        state <= STORE;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RECALL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        dirty <= 1'b0;
                    end
                end
                STORE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        if (STORE_WAIT == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            dirty <= 1'b0;
                        end else begin
                            state <= SWAIT;
                            wcnt  <= '0;
                        end
                    end
                end
                default: begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == WLAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        dirty <= 1'b0;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (cpu_wr) sram[a] <= i;
        else if (state == RECALL) sram[cnt] <= shadow[cnt];
        if (state == STORE) shadow[cnt] <= sram[cnt];
    end
`ifdef SIMULATION
    always @(posedge clk) begin
        if (reset_n && cpu_wr && $isunknown(i)) begin
            $display("nvram_shadow_store: CPU write of X data to %h", a);
            $finish;
        end
        if (reset_n && !busy && !ce_n && rw_n && $isunknown(sram[a])) begin
            $display("nvram_shadow_store: read of X data from %h", a);
            $finish;
        end
    end
`endif
endmodule

// File: tb/tb_nvram_shadow_store.sv
// tb_nvram_shadow_store: randomized bench for nvram_shadow_store against an array-level model of SRAM, shadow and dirty.
module tb_nvram_shadow_store;
    localparam int DATA_W = 4, ADDR_W = 8, DEPTH = 256, STORE_WAIT = 16;
    logic              clk = 1'b0, reset_n = 1'b0;
    logic [ADDR_W-1:0] a = '0;
    logic [DATA_W-1:0] i = '0, o;
    logic              ce_n = 1'b1, rw_n = 1'b1, store_n = 1'b1, recall_n = 1'b1;
    logic              busy, dirty;
    logic              wp = 1'b0;
    logic [DATA_W-1:0] sram_m [DEPTH];
    logic [DATA_W-1:0] shadow_m [DEPTH];
    logic              dirty_m = 1'b0;
    int                checks = 0, errors = 0;

    nvram_shadow_store #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STORE_WAIT(STORE_WAIT)) dut (
        .clk(clk), .reset_n(reset_n), .a(a), .i(i), .o(o), .ce_n(ce_n), .rw_n(rw_n),
        .store_n(store_n), .recall_n(recall_n),
`ifdef NVRAM_WRITE_PROTECT_EN
        .wp(wp),
`endif
        .busy(busy), .dirty(dirty)
    );

    always #5 clk = ~clk;

    task automatic model_recall();
        for (int k = 0; k < DEPTH; k++) sram_m[k] = shadow_m[k];
        dirty_m = 1'b0;
    endtask

    task automatic model_store();
        for (int k = 0; k < DEPTH; k++) shadow_m[k] = sram_m[k];
        dirty_m = 1'b0;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d, input bit takes);
        a = ad; i = d; ce_n = 1'b0; rw_n = 1'b0;
        @(negedge clk);
        ce_n = 1'b1; rw_n = 1'b1;
        if (takes) begin
            sram_m[ad] = d;
            dirty_m = 1'b1;
        end
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] ad, output logic [DATA_W-1:0] d);
        a = ad; ce_n = 1'b0; rw_n = 1'b1;
        @(negedge clk);
        ce_n = 1'b1;
        d = o;
    endtask

    task automatic pulse(input bit st, input bit rc);
        store_n = ~st; recall_n = ~rc;
        @(negedge clk);
        store_n = 1'b1; recall_n = 1'b1;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] ad;
        repeat (3) @(negedge clk);
        checks++; if (o !== 4'h0) begin errors++; $display("FAIL reset_o got %h want 0", o); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
        checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL reset_dirty got %b want 0", dirty); end
        reset_n = 1'b1;
        wait_busy(n);
        checks++; if (n != DEPTH) begin errors++; $display("FAIL powerup_busy_len got %0d want %0d", n, DEPTH); end
        model_recall();
        cpu_read(8'h10, d);
        checks++; if (d !== 4'hF) begin errors++; $display("FAIL powerup_read10 got %h want f", d); end
        checks++; if (dirty !== dirty_m) begin errors++; $display("FAIL powerup_dirty got %b want %b", dirty, dirty_m); end
        for (int k = 0; k < 8; k++) begin
            ad = ADDR_W'($urandom_range(0, DEPTH - 1));
            cpu_read(ad, d);
            checks++; if (d !== sram_m[ad]) begin errors++; $display("FAIL powerup_rand addr %h got %h want %h", ad, d, sram_m[ad]); end
        end
    endtask

    task automatic test_store();
        int n;
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] ad;
        cpu_write(8'h20, 4'h5, 1'b1);
        for (int k = 0; k < 12; k++) cpu_write(ADDR_W'($urandom_range(128, 255)), DATA_W'($urandom), 1'b1);
        checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL store_dirty_set got %b want 1", dirty); end
        pulse(1'b1, 1'b0);
        wait_busy(n);
        checks++; if (n != DEPTH + STORE_WAIT) begin errors++; $display("FAIL store_busy_len got %0d want %0d", n, DEPTH + STORE_WAIT); end
        model_store();
        checks++; if (dirty !== dirty_m) begin errors++; $display("FAIL store_dirty_clr got %b want %b", dirty, dirty_m); end
        for (int k = 0; k < 12; k++) cpu_write(ADDR_W'($urandom_range(0, 255)), DATA_W'($urandom), 1'b1);
        pulse(1'b0, 1'b1);
        wait_busy(n);
        checks++; if (n != DEPTH) begin errors++; $display("FAIL recall_busy_len got %0d want %0d", n, DEPTH); end
        model_recall();
        cpu_read(8'h20, d);
        checks++; if (d !== 4'h5) begin errors++; $display("FAIL store_recall_20 got %h want 5", d); end
        for (int k = 0; k < 16; k++) begin
            ad = ADDR_W'($urandom_range(0, DEPTH - 1));
            cpu_read(ad, d);
            checks++; if (d !== sram_m[ad]) begin errors++; $display("FAIL store_recall_rand addr %h got %h want %h", ad, d, sram_m[ad]); end
        end
    endtask

    task automatic test_recall_discard();
        int n;
        logic [DATA_W-1:0] d;
        cpu_write(8'h20, 4'h3, 1'b1);
        cpu_read(8'h20, d);
        checks++; if (d !== 4'h3) begin errors++; $display("FAIL unsaved_write got %h want 3", d); end
        pulse(1'b0, 1'b1);
        wait_busy(n);
        model_recall();
        cpu_read(8'h20, d);
        checks++; if (d !== shadow_m[8'h20]) begin errors++; $display("FAIL discard_read20 got %h want %h", d, shadow_m[8'h20]); end
        checks++; if (dirty !== dirty_m) begin errors++; $display("FAIL discard_dirty got %b want %b", dirty, dirty_m); end
    endtask

    task automatic test_simultaneous();
        int n;
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] ad;
        for (int k = 0; k < 10; k++) cpu_write(ADDR_W'($urandom_range(0, 255)), DATA_W'($urandom), 1'b1);
        pulse(1'b1, 1'b1);
        repeat (200) @(negedge clk);
        cpu_write(8'h30, ~shadow_m[8'h30], 1'b0);
        pulse(1'b1, 1'b0);
        wait_busy(n);
        checks++; if (n + 202 != DEPTH) begin errors++; $display("FAIL both_busy_len got %0d want %0d", n + 202, DEPTH); end
        model_recall();
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL busy_store_discard got %0d busy cycles want 0", n); end
        cpu_read(8'h30, d);
        checks++; if (d !== shadow_m[8'h30]) begin errors++; $display("FAIL busy_write_drop got %h want %h", d, shadow_m[8'h30]); end
        cpu_read(8'h20, d);
        checks++; if (d !== 4'h5) begin errors++; $display("FAIL both_shadow_kept got %h want 5", d); end
        for (int k = 0; k < 16; k++) begin
            ad = ADDR_W'($urandom_range(0, DEPTH - 1));
            cpu_read(ad, d);
            checks++; if (d !== sram_m[ad]) begin errors++; $display("FAIL both_rand addr %h got %h want %h", ad, d, sram_m[ad]); end
        end
        checks++; if (dirty !== dirty_m) begin errors++; $display("FAIL both_dirty got %b want %b", dirty, dirty_m); end
    endtask

    task automatic test_reset_mid_store();
        int n;
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DEPTH; k++) cpu_write(ADDR_W'(k), 4'hA, 1'b1);
        pulse(1'b1, 1'b0);
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (o !== 4'h0) begin errors++; $display("FAIL abort_o got %h want 0", o); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b want 1", busy); end
        for (int k = 0; k < 100; k++) shadow_m[k] = sram_m[k];
        @(negedge clk);
        reset_n = 1'b1;
        wait_busy(n);
        checks++; if (n != DEPTH) begin errors++; $display("FAIL abort_recall_len got %0d want %0d", n, DEPTH); end
        model_recall();
        for (int k = 0; k < DEPTH; k++) begin
            cpu_read(ADDR_W'(k), d);
            checks++; if (d !== sram_m[k]) begin errors++; $display("FAIL abort_word addr %h got %h want %h", k, d, sram_m[k]); end
        end
        checks++; if (dirty !== dirty_m) begin errors++; $display("FAIL abort_dirty got %b want %b", dirty, dirty_m); end
    endtask

`ifdef NVRAM_WRITE_PROTECT_EN
    task automatic test_write_protect();
        int n;
        logic [DATA_W-1:0] d;
        wp = 1'b1;
        cpu_write(8'h40, ~sram_m[8'h40], 1'b0);
        pulse(1'b1, 1'b0);
        n = 0;
        repeat (4) begin
            if (busy) n++;
            @(negedge clk);
        end
        checks++; if (n != 0) begin errors++; $display("FAIL wp_busy got %0d busy cycles want 0", n); end
        checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL wp_dirty got %b want 0", dirty); end
        cpu_read(8'h40, d);
        checks++; if (d !== sram_m[8'h40]) begin errors++; $display("FAIL wp_write got %h want %h", d, sram_m[8'h40]); end
        wp = 1'b0;
    endtask
`endif

    initial begin
        for (int k = 0; k < DEPTH; k++) shadow_m[k] = 4'hF;
        test_reset();
        test_store();
        test_recall_discard();
        test_simultaneous();
        test_reset_mid_store();
`ifdef NVRAM_WRITE_PROTECT_EN
        test_write_protect();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nvram_shadow_store.md
Name: nvram_shadow_store

Overview:
- Parametrised successor to the X2212 NVRAM model: a DEPTH x DATA_W static RAM backed by a non-volatile shadow array of the same size.
- Whole-array STORE (SRAM to shadow) and RECALL (shadow to SRAM) run under a sequencer, with a busy flag and a dirty flag.
- Sits on the CPU bus for high-score/settings storage. Firmware sees X2212 semantics plus realistic store/recall timing.

Parameters:
- DATA_W, 4, data word width in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- STORE_WAIT, 16, extra idle cycles after the last STORE word copy, to model EEPROM programming time (0 allowed).
- INIT_VAL, all ones, value loaded into the shadow array at simulation start (the shadow array is never reset).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- a  in  ADDR_W  CPU word address.
- i  in  DATA_W  CPU write data.
- o  out  DATA_W  CPU read data, registered.
- ce_n  in  1  chip enable, active low.
- rw_n  in  1  1 = read, 0 = write.
- store_n  in  1  store request, active low, edge triggered.
- recall_n  in  1  recall request, active low, edge triggered.
- busy  out  1  high while STORE or RECALL is in progress.
- dirty  out  1  SRAM has been written since the last completed STORE or RECALL.

Behaviour:
- Reset values (asserted asynchronously):
  - o = 0, dirty = 0, state = RECALL, word counter = 0, wait counter = 0, busy = 1.
  - Edge-detect registers for store_n and recall_n = 1.
  - Neither the SRAM nor the shadow array is reset.
- Power-up recall: on reset release the block performs an automatic full RECALL, as the X2212 does at power-on.
- Reads: o <= sram[a] every clk, independent of ce_n and of state. Latency is 1 cycle.
- CPU writes:
  - In IDLE, ce_n == 0 && rw_n == 0 writes sram[a] <= i and sets dirty <= 1.
  - In any other state, CPU writes are dropped and dirty is unchanged.
- Requests:
  - store_n and recall_n are registered each cycle.
  - A request is a 1 to 0 transition between the registered value and the current input.
  - Requests are accepted only in IDLE. Requests seen while busy are discarded, not queued.
  - If both requests arrive in the same cycle, RECALL wins and STORE is discarded.
- State machine:
  - IDLE:
    - Recall request -> RECALL with counter = 0.
    - Store request -> STORE with counter = 0.
  - RECALL:
    - Each cycle, sram[cnt] <= shadow[cnt] and cnt increments.
    - After the cycle with cnt == DEPTH-1: dirty <= 0, state -> IDLE.
    - Total duration is DEPTH cycles.
  - STORE:
    - Each cycle, shadow[cnt] <= sram[cnt] and cnt increments.
    - After cnt == DEPTH-1: if STORE_WAIT == 0, dirty <= 0 and state -> IDLE; otherwise state -> SWAIT with wcnt = 0.
  - SWAIT:
    - wcnt increments each cycle.
    - When wcnt == STORE_WAIT-1: dirty <= 0, state -> IDLE.
    - Total STORE duration is DEPTH + STORE_WAIT cycles.
- busy is a registered output: it is 1 in RECALL, STORE and SWAIT, and falls in the same cycle state becomes IDLE.
- The word counter is ADDR_W bits wide and wraps naturally. Termination is decoded from cnt == DEPTH-1; the wrap is never relied on.
- Reset mid-operation:
  - Aborts immediately. Shadow words already copied keep their new values; the rest keep their old values.
  - Then the power-up RECALL runs, so the SRAM reflects that partially updated shadow.
- Simulation only (ifdef SIMULATION):
  - $display and $finish on a CPU write of X data.
  - $display and $finish on a read of X data from the SRAM.

Optional Feature:
- Macro NVRAM_WRITE_PROTECT_EN.
- When defined:
  - Adds input wp (1 bit).
  - While wp == 1, CPU writes are ignored and store requests are discarded.
  - Recall still works.
- When undefined: no wp port, behaviour exactly as above.

Test Plan:
- Release reset with shadow = INIT_VAL (all ones), DEPTH = 256 -> busy high for exactly 256 cycles, then read a = 0x10 returns 4'hF one cycle later, dirty = 0.
- In IDLE, write 4'h5 to 0x20 -> dirty = 1; pulse store_n low -> busy high for 256+16 = 272 cycles, then dirty = 0; pulse recall_n -> read 0x20 returns 4'h5.
- Write 4'h3 to 0x20 without storing, then recall -> 0x20 returns the stored 4'h5, dirty = 0.
- store_n and recall_n fall in the same cycle -> RECALL only: busy for 256 cycles, shadow unchanged. A CPU write to 0x30 during busy is dropped (0x30 keeps its old value).
- Assert reset_n low 100 cycles into a STORE, after writing 4'hA to every SRAM word -> o = 0 and busy = 1 immediately; after auto-recall, words 0x00-0x63 read 4'hA and 0x64-0xFF read 4'hF.
- With NVRAM_WRITE_PROTECT_EN and wp = 1 -> a write to 0x40 and a store pulse have no effect; busy stays 0 and dirty stays 0.
